// File: rtl/gray_bus_receiver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_bus_receiver_pkg
//  Description : Shared types and constants for the Gray-coded bus receiver.
//                Holds the receiver FSM state type, default parameter values
//                and a Gray-to-binary helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_bus_receiver_pkg;

    // Default bus width, stability window and error-counter width.
    localparam int c_default_n             = 8;
    localparam int c_default_stable_cycles = 4;
    localparam int c_default_err_w         = 8;

    // Receiver lock state.
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } rx_state_t;

    // Gray-to-binary decode of a zero-extended value up to 32 bits wide.
    // Each binary bit is the XOR of all Gray bits at or above it, so
    // zero-extension of a narrower code does not change the result.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int s = 1; s < 32; s++) begin
            bin = bin ^ (gray >> s);
        end
        return bin;
    endfunction

endpackage : gray_bus_receiver_pkg
`default_nettype wire

// File: rtl/gray_bus_receiver_gray2bin.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Combinational N-bit Gray-to-binary decoder.
//                bin[N-1] = gray[N-1]; bin[i] = bin[i+1] ^ gray[i].
//  Ports       : i_gray  in  N  Gray-coded value
//                o_bin   out N  binary equivalent
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin
    import gray_bus_receiver_pkg::*;
#(
    parameter int N = c_default_n
) (
    input  logic [N-1:0] i_gray,
    output logic [N-1:0] o_bin
);

    // Each output bit is the reduction XOR of the Gray bits from the MSB
    // down to that position, which unrolls the ripple recurrence.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[N-1:i];
    end

endmodule : gray2bin
`default_nettype wire

// File: rtl/gray_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_bus_receiver
//  Description : Receives an asynchronous Gray-coded count bus. Synchronizes
//                it with two flops, waits for STABLE_CYCLES identical
//                samples, decodes accepted values to binary, checks each
//                accepted step for a single-bit change and reports the step
//                direction.
//  Ports       : clk        in  1      system clock
//                reset      in  1      asynchronous active-high reset
//                gray_in    in  N      asynchronous Gray-coded bus
//                bin_out    out N      binary decode of last accepted value
//                valid      out 1      pulse on each newly accepted value
//                dir_up     out 1      last legal step was +1 mod 2^N
//                step_err   out 1      pulse: accepted step not single-bit
//                locked     out 1      a value was accepted since reset
//                err_count  out ERR_W  saturating count of step_err pulses
//  Config      : GRAY_RX_ERRCNT_EN - when defined, err_count is a real
//                saturating counter; otherwise it is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_bus_receiver
    import gray_bus_receiver_pkg::*;
#(
    parameter int N             = c_default_n,
    parameter int STABLE_CYCLES = c_default_stable_cycles,
    parameter int ERR_W         = c_default_err_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             valid,
    output logic             dir_up,
    output logic             step_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit.
    localparam int c_cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------------
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gray_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Stability filter: any synchronized change reloads the candidate and
    // restarts the count, so latency is measured from the last change.
    // ------------------------------------------------------------------------
    logic [N-1:0]       r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (r_cnt != c_cnt_max) begin
            r_cnt  <= r_cnt + c_cnt_w'(1);
        end
    end

    // The count holds at its maximum, so a settled value stays "stable"
    // every cycle; the FSM ignores it once it matches the accepted value.
    assign w_stable = (r_sync2 == r_cand) && (r_cnt == c_cnt_max);

    // ------------------------------------------------------------------------
    // Decoders for the candidate and the last accepted value
    // ------------------------------------------------------------------------
    logic [N-1:0] r_acc_gray;
    logic [N-1:0] w_cand_bin;
    logic [N-1:0] w_acc_bin;

    gray2bin #(.N(N)) u_cand_dec (
        .i_gray (r_cand),
        .o_bin  (w_cand_bin)
    );

    gray2bin #(.N(N)) u_acc_dec (
        .i_gray (r_acc_gray),
        .o_bin  (w_acc_bin)
    );

    // A legal Gray step flips exactly one bit; N-bit arithmetic makes the
    // all-ones to zero wrap count as an up-step.
    logic w_legal;
    logic w_is_up;

    assign w_legal = $onehot(r_acc_gray ^ r_cand);
    assign w_is_up = (w_cand_bin == (w_acc_bin + N'(1)));

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    rx_state_t r_state;
    rx_state_t w_state_next;
    logic      w_accept;
    logic      w_check;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                // First value after reset has no predecessor to check.
                if (w_stable) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A bounce back to the accepted value is silently ignored.
                if (w_stable && (r_cand != r_acc_gray)) begin
                    w_accept = 1'b1;
                    w_check  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    logic [N-1:0] r_bin;
    logic         r_valid;
    logic         r_dir_up;
    logic         r_step_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_gray <= '0;
            r_bin      <= '0;
            r_valid    <= 1'b0;
            r_dir_up   <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_valid    <= w_accept;
            r_step_err <= w_check && !w_legal;
            if (w_accept) begin
                r_acc_gray <= r_cand;
                r_bin      <= w_cand_bin;
            end
            // Direction is only meaningful for a legal step; an illegal
            // jump leaves the previous direction in place.
            if (w_check && w_legal) begin
                r_dir_up <= w_is_up;
            end
        end
    end

    assign bin_out  = r_bin;
    assign valid    = r_valid;
    assign dir_up   = r_dir_up;
    assign step_err = r_step_err;
    assign locked   = (r_state == ST_LOCKED);

    // ------------------------------------------------------------------------
    // Optional saturating step-error counter
    // ------------------------------------------------------------------------
`ifdef GRAY_RX_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_check && !w_legal && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

endmodule : gray_bus_receiver
`default_nettype wire

// File: tb/tb_gray_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gray_bus_receiver
//  Description : Self-checking bench for gray_bus_receiver (N=8,
//                STABLE_CYCLES=4). A behavioural model predicts every output
//                each cycle; directed scenarios add hand-computed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_bus_receiver;

    localparam int N  = 8;
    localparam int S  = 4;
    localparam int EW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  gray_in = '0;
    logic [N-1:0]  bin_out;
    logic          valid;
    logic          dir_up;
    logic          step_err;
    logic          locked;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    gray_bus_receiver #(
        .N             (N),
        .STABLE_CYCLES (S),
        .ERR_W         (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .valid     (valid),
        .dir_up    (dir_up),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < N; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [7:0] b2g(input int b);
        logic [7:0] v;
        v = 8'(b);
        return v ^ (v >> 1);
    endfunction

    // A value is accepted once the synchronized bus has shown it on S+1
    // consecutive clock edges; the reset state counts as one such sample
    // of zero.
    logic [7:0] m_s1 = '0, m_s2 = '0, m_runval = '0, m_pre = '0;
    logic [7:0] m_acc_gray = '0, m_bin = '0;
    int         m_run = 1;
    int         m_err = 0;
    bit         m_locked = 0, m_valid = 0, m_step_err = 0, m_dir_up = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_runval = '0; m_run = 1;
            m_acc_gray = '0; m_bin = '0; m_err = 0;
            m_locked = 0; m_valid = 0; m_step_err = 0; m_dir_up = 0;
        end else begin
            m_pre = m_s2;
            if (m_pre == m_runval) begin
                if (m_run < S + 1) m_run++;
            end else begin
                m_runval = m_pre;
                m_run    = 1;
            end
            m_valid    = 0;
            m_step_err = 0;
            if (m_run >= S + 1 && (!m_locked || m_pre != m_acc_gray)) begin
                m_valid = 1;
                if (m_locked) begin
                    if ($countones(m_pre ^ m_acc_gray) == 1) begin
                        m_dir_up = (g2b(m_pre) == 8'(g2b(m_acc_gray) + 8'd1));
                    end else begin
                        m_step_err = 1;
                        if (m_err < 255) m_err++;
                    end
                end
                m_locked   = 1;
                m_acc_gray = m_pre;
                m_bin      = g2b(m_pre);
            end
            m_s2 = m_s1;
            m_s1 = gray_in;
        end
    end

    function automatic int exp_err(input int e);
`ifdef GRAY_RX_ERRCNT_EN
        return e;
`else
        return 0 * e;
`endif
    endfunction

    // Per-cycle comparison against the model, on the inactive edge.
    initial forever begin
        @(negedge clk);
        chk("valid",     32'(valid),     32'(m_valid));
        chk("bin_out",   32'(bin_out),   32'(m_bin));
        chk("dir_up",    32'(dir_up),    32'(m_dir_up));
        chk("step_err",  32'(step_err),  32'(m_step_err));
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err_count", 32'(err_count), 32'(exp_err(m_err)));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Counts edges from the call until valid is seen (bounded).
    task automatic wait_valid(input int max, output int edges, output bit seen);
        edges = 0;
        seen  = 0;
        while (edges < max && !seen) begin
            @(posedge clk);
            #2;
            edges++;
            if (valid) seen = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    int e;
    bit seen;
    int nv, ndn, nerr;

    initial begin
        // --- Scenario 1: lock onto a steady 0 after reset ------------------
        gray_in = 8'h00;
        tick(3);
        reset = 1'b0;
        wait_valid(20, e, seen);
        chk("t1_seen",     32'(seen), 1);
        chk("t1_latency",  32'(e), 4);   // reset-state sample counts as one
        chk("t1_bin",      32'(bin_out), 0);
        chk("t1_locked",   32'(locked), 1);
        chk("t1_dir_up",   32'(dir_up), 0);
        chk("t1_step_err", 32'(step_err), 0);

        // --- Scenario 4: illegal jump 00 -> 03 ------------------------------
        tick(3);
        gray_in = 8'h03;
        wait_valid(20, e, seen);
        chk("t4_seen",      32'(seen), 1);
        chk("t4_latency",   32'(e), 7);  // edges k..k+6 inclusive
        chk("t4_step_err",  32'(step_err), 1);
        chk("t4_bin",       32'(bin_out), 2);
        chk("t4_dir_up",    32'(dir_up), 0);
        chk("t4_err_count", 32'(err_count), 32'(exp_err(1)));
        tick(1);
        chk("t4_err_pulse_len", 32'(step_err), 0);

        // --- Scenario 2: full walk 0..255..0 --------------------------------
        gray_in = 8'h00;
        do_reset();
        wait_valid(20, e, seen);
        chk("t2_lock_seen", 32'(seen), 1);
        nv = 0; ndn = 0; nerr = 0;
        for (int i = 1; i <= 256; i++) begin
            gray_in = b2g(i % 256);
            for (int c = 0; c < 10; c++) begin
                tick(1);
                if (valid) begin
                    nv++;
                    if (!dir_up) ndn++;
                end
                if (step_err) nerr++;
            end
        end
        chk("t2_valid_count", 32'(nv), 256);
        chk("t2_dir_down",    32'(ndn), 0);
        chk("t2_step_errs",   32'(nerr), 0);
        chk("t2_final_bin",   32'(bin_out), 0);
        chk("t2_wrap_dir_up", 32'(dir_up), 1);

        // --- Scenario 3: bounce between 01 and 03 ---------------------------
        gray_in = 8'h01;
        do_reset();
        wait_valid(20, e, seen);
        chk("t3_lock_seen", 32'(seen), 1);
        chk("t3_lock_bin",  32'(bin_out), 1);
        nv = 0;
        for (int j = 0; j < 10; j++) begin
            gray_in = (j % 2 == 0) ? 8'h03 : 8'h01;
            for (int c = 0; c < 2; c++) begin
                tick(1);
                if (valid) nv++;
            end
        end
        chk("t3_bounce_valids", 32'(nv), 0);
        gray_in = 8'h03;
        wait_valid(20, e, seen);
        chk("t3_seen",     32'(seen), 1);
        chk("t3_bin",      32'(bin_out), 2);
        chk("t3_dir_up",   32'(dir_up), 1);
        chk("t3_step_err", 32'(step_err), 0);

        // --- Scenario 5: 300 illegal jumps saturate the counter -------------
        gray_in = 8'h00;
        do_reset();
        wait_valid(20, e, seen);
        chk("t5_lock_seen", 32'(seen), 1);
        nerr = 0;
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 8'h03 : 8'h00;
            for (int c = 0; c < 8; c++) begin
                tick(1);
                if (step_err) nerr++;
            end
        end
        chk("t5_step_err_pulses", 32'(nerr), 300);
        chk("t5_err_saturated",   32'(err_count), 32'(exp_err(255)));

        // --- Scenario 6: reset in the middle of a stability count -----------
        gray_in = 8'h00;
        do_reset();
        wait_valid(20, e, seen);
        chk("t6_lock_seen", 32'(seen), 1);
        gray_in = 8'h01;
        tick(4);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid",     32'(valid), 0);
        chk("t6_rst_bin",       32'(bin_out), 0);
        chk("t6_rst_dir_up",    32'(dir_up), 0);
        chk("t6_rst_step_err",  32'(step_err), 0);
        chk("t6_rst_locked",    32'(locked), 0);
        chk("t6_rst_err_count", 32'(err_count), 0);
        tick(1);
        reset = 1'b0;
        wait_valid(20, e, seen);
        chk("t6_seen",     32'(seen), 1);
        chk("t6_latency",  32'(e), 7);
        chk("t6_bin",      32'(bin_out), 1);
        chk("t6_step_err", 32'(step_err), 0);
        chk("t6_locked",   32'(locked), 1);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gray_bus_receiver
`default_nettype wire

// File: doc/gray_bus_receiver.md
# gray_bus_receiver

Receiving end of the Gray-coded count bus driven by the Gray counter system. It samples an asynchronous N-bit Gray-coded input, synchronizes and debounces it, and decodes it to binary. It checks every accepted transition for a legal single-bit step and reports the step direction. It sits on the receiving board or domain in place of the counter logic and feeds the seven-segment/LED display path with clean binary data.

## Interface
- N, 8, bus width in bits (N >= 2)
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a value is accepted (>= 1)
- ERR_W, 8, width of the step-error counter
---
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gray_in  in  N  asynchronous Gray-coded bus
- bin_out  out  N  binary decode of last accepted value
- valid  out  1  one-cycle pulse on each newly accepted value
- dir_up  out  1  last accepted step was +1 modulo 2^N
- step_err  out  1  one-cycle pulse: accepted step was not a single-bit change
- locked  out  1  at least one value accepted since reset
- err_count  out  ERR_W  saturating count of step_err pulses

## Operation
- Two-flop synchronizer on gray_in: sync1 then sync2, both reset to 0.
- Stability filter, candidate register cand (N bits) plus counter cnt:
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - Otherwise, while cnt < STABLE_CYCLES-1: cnt increments.
  - cnt == STABLE_CYCLES-1 and sync2 == cand: the value is stable and goes to acceptance (cnt holds).
- FSM states: UNLOCKED (reset state) and LOCKED.
  - UNLOCKED, stable value: acc_gray <= cand, bin_out <= decode(cand), valid = 1, locked = 1, go to LOCKED. No step check; dir_up stays 0.
  - LOCKED, stable value equal to acc_gray: no action, no valid. This covers a bounce back to the same value.
  - LOCKED, stable value different from acc_gray: accept it and pulse valid.
    - If popcount(acc_gray ^ cand) == 1: dir_up <= (decode(cand) == decode(acc_gray)+1 mod 2^N).
    - Otherwise: step_err pulse, dir_up unchanged, and err_count increments, saturating at 2^ERR_W-1.
- Decoding: bin[N-1] = g[N-1]; bin[i] = bin[i+1] ^ g[i].
- Wrap-around:
  - Gray of 2^N-1 to Gray of 0 is a legal step with dir_up = 1.
  - 0 to 2^N-1 is legal with dir_up = 0.
- Reset asserted at any time clears all state immediately, including mid-count and mid-acceptance.
- Reset values of all outputs: 0.

## Timing
- gray_in changes and is stable before edge k. sync2 holds the new value after edge k+1, cand loads at edge k+2, and acceptance happens at edge k+STABLE_CYCLES+2.
- The following are registered at the acceptance edge and are visible in the cycle after that edge:
  - valid, bin_out, dir_up, step_err
  - locked, on the first acceptance only
  - err_count
- valid and step_err are high for exactly one cycle.
- A sync2 change during the count restarts the count, so latency is measured from the last change.
- Minimum spacing between valid pulses: STABLE_CYCLES+1 cycles.

## Configuration
- GRAY_RX_ERRCNT_EN defined:
  - err_count is implemented as above.
- GRAY_RX_ERRCNT_EN undefined:
  - No counter register is built; err_count is tied to 0.
  - step_err pulses still occur.
  - The port list is identical in both builds.

## Structure
- Shared package holds:
  - FSM state typedef (ST_UNLOCKED, ST_LOCKED)
  - default constants for N, STABLE_CYCLES, ERR_W
  - a Gray-to-binary function
- One sub-module: gray2bin, a combinational N-bit decoder, instantiated twice (for cand and for acc_gray).
- Synchronizer, filter, FSM and error counter live in the top module.

## Test plan
All scenarios use N=8 and STABLE_CYCLES=4.
1. Reset, then gray_in = 8'h00 steady -> valid pulse after edge k+6, bin_out = 0, locked = 1, dir_up = 0, step_err = 0.
2. Walk gray_in through Gray codes 0..255 and back to 0, holding 10 cycles each -> 256 valid pulses, bin_out tracks the count, dir_up = 1 throughout including the 255->0 wrap, step_err never asserted.
3. Change gray_in 8'h01 -> 8'h03 (bin 1 -> 2) but toggle it back to 8'h01 every 2 cycles for 20 cycles, then hold 8'h03 -> no valid during the bounce; one valid with bin_out = 2, dir_up = 1 after the final hold.
4. Jump from accepted 8'h00 directly to 8'h03 -> valid and step_err pulse together, bin_out = 2, err_count = 1 (0 without GRAY_RX_ERRCNT_EN).
5. Force 300 illegal jumps -> err_count saturates at 255.
6. Assert reset during the stability count of a new value -> all outputs 0 and locked = 0; after release the stable value is re-acquired with no step_err.
